// File: rtl/patch_row_sequencer_if.sv
// patch_row_sequencer_if: host, reducer-bank, weight-table and result bus of patch_row_sequencer
// Ports (slave = sequencer side, master = host/bank side):
//   new_val/new_ack/new_patch/new_row/new_col             host patch offer
//   red_done/red_avail/red_sum/red_patch/red_row/red_col   per-reducer status, packed per reducer
//   red_init/conf_patch_num/conf_row/conf_col/conf_sum     one-hot init plus shared conf bus
//   wt_rd/wt_patch/wt_rowofs/wt_data/conf_weights          weight table read and its registered copy
//   res_val/res_rdy/res_sum/res_patch                      finished patch result
// PATCH_SEQ_OVERRUN_CHECK_EN adds cur_row (to sequencer) and overrun (from sequencer).
interface patch_row_sequencer_if #(
    parameter int N_REDUCER  = 4,
    parameter int N_PATCH    = 64,
    parameter int PATCH_SIZE = 8,
    parameter int PATCH_ROWS = 8,
    parameter int N_COL_SIZE = 11,
    parameter int N_ROW_SIZE = 11,
    parameter int FP_SIZE    = 32
);
    localparam int PW = $clog2(N_PATCH);
    localparam int RW = $clog2(PATCH_ROWS);
    logic                            new_val;
    logic                            new_ack;
    logic [PW-1:0]                   new_patch;
    logic [N_ROW_SIZE-1:0]           new_row;
    logic [N_COL_SIZE-1:0]           new_col;
    logic [N_REDUCER-1:0]            red_done;
    logic [N_REDUCER-1:0]            red_avail;
    logic [N_REDUCER*FP_SIZE-1:0]    red_sum;
    logic [N_REDUCER*PW-1:0]         red_patch;
    logic [N_REDUCER*N_ROW_SIZE-1:0] red_row;
    logic [N_REDUCER*N_COL_SIZE-1:0] red_col;
    logic [N_REDUCER-1:0]            red_init;
    logic [PW-1:0]                   conf_patch_num;
    logic [N_ROW_SIZE-1:0]           conf_row;
    logic [N_COL_SIZE-1:0]           conf_col;
    logic [FP_SIZE-1:0]              conf_sum;
    logic                            wt_rd;
    logic [PW-1:0]                   wt_patch;
    logic [RW-1:0]                   wt_rowofs;
    logic [PATCH_SIZE*FP_SIZE-1:0]   wt_data;
    logic [PATCH_SIZE*FP_SIZE-1:0]   conf_weights;
    logic                            res_val;
    logic                            res_rdy;
    logic [FP_SIZE-1:0]              res_sum;
    logic [PW-1:0]                   res_patch;
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
    logic [N_ROW_SIZE-1:0]           cur_row;
    logic                            overrun;
`endif
    modport slave (
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
        input  cur_row,
        output overrun,
`endif
        input  new_val, new_patch, new_row, new_col,
        input  red_done, red_avail, red_sum, red_patch, red_row, red_col,
        input  wt_data, res_rdy,
        output new_ack, red_init, conf_patch_num, conf_row, conf_col, conf_sum,
        output wt_rd, wt_patch, wt_rowofs, conf_weights,
        output res_val, res_sum, res_patch
    );
    modport master (
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
        output cur_row,
        input  overrun,
`endif
        output new_val, new_patch, new_row, new_col,
        output red_done, red_avail, red_sum, red_patch, red_row, red_col,
        output wt_data, res_rdy,
        input  new_ack, red_init, conf_patch_num, conf_row, conf_col, conf_sum,
        input  wt_rd, wt_patch, wt_rowofs, conf_weights,
        input  res_val, res_sum, res_patch
    );
endinterface

// File: rtl/patch_row_sequencer.sv
// patch_row_sequencer: schedules patch rows onto a bank of row reducers, chaining partial sums
// Ports:
//   CLK    clock, single domain
//   RESET  synchronous active-high reset
//   bus    patch_row_sequencer_if.slave: host offer, reducer status/init, weight table, result
// Optional: PATCH_SEQ_OVERRUN_CHECK_EN builds the sticky overrun flag (bus.cur_row in, bus.overrun out).
module patch_row_sequencer #(
    parameter int N_REDUCER  = 4,
    parameter int N_PATCH    = 64,
    parameter int PATCH_SIZE = 8,
    parameter int PATCH_ROWS = 8,
    parameter int N_COL_SIZE = 11,
    parameter int N_ROW_SIZE = 11,
    parameter int FP_SIZE    = 32
) (
    input logic CLK,
    input logic RESET,
    patch_row_sequencer_if.slave bus
);
    localparam int PW = $clog2(N_PATCH);
    localparam int RW = $clog2(PATCH_ROWS);
    localparam int KW = N_REDUCER > 1 ? $clog2(N_REDUCER) : 1;
    typedef enum logic [1:0] {IDLE, WT_RD, ISSUE, EMIT} state_t;
    state_t                  state;
    logic [N_REDUCER-1:0]    pending, clr, rot, free;
    logic [2*N_REDUCER-1:0]  dbl;
    logic [RW-1:0]           rowofs [N_REDUCER];
    logic [KW-1:0]           rr, k, rr_pick, free_pick, sel;
    logic                    cont;
    logic [PW-1:0]           lat_patch;
    logic [N_ROW_SIZE-1:0]   lat_row;
    logic [N_COL_SIZE-1:0]   lat_col;
    logic [FP_SIZE-1:0]      sums    [N_REDUCER];
    logic [PW-1:0]           patches [N_REDUCER];
    logic [N_ROW_SIZE-1:0]   rows    [N_REDUCER];
    logic [N_COL_SIZE-1:0]   cols    [N_REDUCER];
    logic [N_ROW_SIZE-1:0]   next_row;
    always_comb begin
        for (int i = 0; i < N_REDUCER; i++) begin
            sums[i]    = bus.red_sum[i*FP_SIZE +: FP_SIZE];
            patches[i] = bus.red_patch[i*PW +: PW];
            rows[i]    = bus.red_row[i*N_ROW_SIZE +: N_ROW_SIZE];
            cols[i]    = bus.red_col[i*N_COL_SIZE +: N_COL_SIZE];
        end
        // rotate so bit 0 is the reducer at the rr pointer; lowest set bit wins
        dbl     = {pending, pending} >> rr;
        rot     = dbl[N_REDUCER-1:0];
        rr_pick = '0;
        for (int j = N_REDUCER-1; j >= 0; j--)
            if (rot[j]) rr_pick = KW'((int'(rr) + j) % N_REDUCER);
        free      = bus.red_avail & ~pending;
        free_pick = '0;
        for (int i = N_REDUCER-1; i >= 0; i--)
            if (free[i]) free_pick = KW'(i);
        sel      = state == IDLE ? rr_pick : k;
        next_row = rows[sel] + N_ROW_SIZE'(1);
        clr      = ((state == ISSUE && cont) || (state == EMIT && bus.res_rdy)) ? N_REDUCER'(1) << k : '0;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state              <= IDLE;
            pending            <= '0;
            rr                 <= '0;
            k                  <= '0;
            cont               <= 1'b0;
            lat_patch          <= '0;
            lat_row            <= '0;
            lat_col            <= '0;
            for (int i = 0; i < N_REDUCER; i++) rowofs[i] <= '0;
            bus.new_ack        <= 1'b0;
            bus.red_init       <= '0;
            bus.conf_patch_num <= '0;
            bus.conf_row       <= '0;
            bus.conf_col       <= '0;
            bus.conf_sum       <= '0;
            bus.wt_rd          <= 1'b0;
            bus.wt_patch       <= '0;
            bus.wt_rowofs      <= '0;
            bus.conf_weights   <= '0;
            bus.res_val        <= 1'b0;
            bus.res_sum        <= '0;
            bus.res_patch      <= '0;
        end else begin
            bus.new_ack  <= 1'b0;
            bus.wt_rd    <= 1'b0;
            bus.red_init <= '0;
            // a done arriving in the same cycle as the service clear must survive
            pending      <= (pending & ~clr) | bus.red_done;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        k    <= rr_pick;
                        rr   <= rr_pick == KW'(N_REDUCER-1) ? '0 : rr_pick + KW'(1);
                        cont <= 1'b1;
                        if (rowofs[rr_pick] == RW'(PATCH_ROWS-1)) begin
                            state         <= EMIT;
                            bus.res_val   <= 1'b1;
                            bus.res_sum   <= sums[rr_pick];
                            bus.res_patch <= patches[rr_pick];
                        end else begin
                            state         <= WT_RD;
                            bus.wt_rd     <= 1'b1;
                            bus.wt_patch  <= patches[rr_pick];
                            bus.wt_rowofs <= rowofs[rr_pick] + RW'(1);
                        end
                    end else if (bus.new_val && |free) begin
                        k                 <= free_pick;
                        cont              <= 1'b0;
                        rowofs[free_pick] <= '0;
                        lat_patch         <= bus.new_patch;
                        lat_row           <= bus.new_row;
                        lat_col           <= bus.new_col;
                        bus.new_ack       <= 1'b1;
                        bus.wt_rd         <= 1'b1;
                        bus.wt_patch      <= bus.new_patch;
                        bus.wt_rowofs     <= '0;
                        state             <= WT_RD;
                    end
                end
                WT_RD: state <= ISSUE;
                ISSUE: begin
                    bus.red_init     <= N_REDUCER'(1) << k;
                    bus.conf_weights <= bus.wt_data;
                    state            <= IDLE;
                    if (cont) begin
                        bus.conf_sum       <= sums[k];
                        bus.conf_row       <= next_row;
                        bus.conf_col       <= cols[k];
                        bus.conf_patch_num <= patches[k];
                        rowofs[k]          <= rowofs[k] + RW'(1);
                    end else begin
                        bus.conf_sum       <= '0;
                        bus.conf_row       <= lat_row;
                        bus.conf_col       <= lat_col;
                        bus.conf_patch_num <= lat_patch;
                    end
                end
                EMIT: begin
                    if (bus.res_rdy) begin
                        bus.res_val <= 1'b0;
                        rowofs[k]   <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
    // a continuation whose row is already streaming was initialised too late
    always_ff @(posedge CLK) begin
        if (RESET)
            bus.overrun <= 1'b0;
        else if (state == ISSUE && cont && next_row <= bus.cur_row)
            bus.overrun <= 1'b1;
    end
`else
`endif
endmodule

// File: tb/tb_patch_row_sequencer.sv
// tb_patch_row_sequencer: scoreboard bench for patch_row_sequencer with PATCH_ROWS=2
module tb_patch_row_sequencer;
    logic CLK = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic res_prev = 1'b0;

    typedef struct {
        logic [3:0]  init;
        logic [31:0] sum;
        logic [10:0] row;
        logic [10:0] col;
        logic [5:0]  patch;
        logic        rowofs;
        int          at;
    } init_t;
    typedef struct {
        logic [31:0] sum;
        logic [5:0]  patch;
        int          at;
    } res_t;
    init_t iq[$];
    res_t  rq[$];

    patch_row_sequencer_if #(.PATCH_ROWS(2)) b ();
    patch_row_sequencer #(.PATCH_ROWS(2)) dut (.CLK(CLK), .RESET(RESET), .bus(b));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [255:0] wt_pat(input logic [5:0] p, input logic r);
        return {8{24'hA5A5A5, 1'b0, r, p}};
    endfunction

    // weight table: data valid exactly one clock after the read strobe, zero otherwise
    always @(posedge CLK) b.wt_data <= b.wt_rd ? wt_pat(b.wt_patch, b.wt_rowofs) : '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_red(input int i, input logic [31:0] s, input logic [5:0] p,
                           input logic [10:0] r, input logic [10:0] c);
        b.red_sum[i*32 +: 32]   = s;
        b.red_patch[i*6 +: 6]   = p;
        b.red_row[i*11 +: 11]   = r;
        b.red_col[i*11 +: 11]   = c;
    endtask

    task automatic wait_ack(input int exp_cyc);
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge CLK);
            if (b.new_ack) begin
                seen = 1'b1;
                chk("ack_cycle", cyc, exp_cyc);
            end
        end
        chk("ack_seen", seen, 1'b1);
    endtask

    task automatic wait_q();
        for (int t = 0; t < 20 && iq.size() != 0; t++) begin
            @(negedge CLK);
            #2;
        end
        chk("init_drain", iq.size(), 0);
    endtask

    task automatic wait_r();
        for (int t = 0; t < 20 && rq.size() != 0; t++) begin
            @(negedge CLK);
            #2;
        end
        chk("res_drain", rq.size(), 0);
    endtask

    // monitor: every wt_rd, red_init and result is matched against the scoreboard
    always @(negedge CLK) begin
        init_t e;
        res_t  r;
        if (b.wt_rd) begin
            if (iq.size() == 0) chk("wt_rd_unexpected", b.wt_rd, 1'b0);
            else begin
                chk("wt_cycle", cyc, iq[0].at - 2);
                chk("wt_patch", b.wt_patch, iq[0].patch);
                chk("wt_rowofs", b.wt_rowofs, iq[0].rowofs);
            end
        end
        if (b.red_init != 4'b0) begin
            if (iq.size() == 0) chk("init_unexpected", b.red_init, 4'b0);
            else begin
                e = iq.pop_front();
                chk("init_cycle", cyc, e.at);
                chk("init_onehot", b.red_init, e.init);
                chk("conf_sum", b.conf_sum, e.sum);
                chk("conf_row", b.conf_row, e.row);
                chk("conf_col", b.conf_col, e.col);
                chk("conf_patch", b.conf_patch_num, e.patch);
                chk("conf_weights", b.conf_weights, wt_pat(e.patch, e.rowofs));
            end
        end
        if (b.res_val && !res_prev) begin
            if (rq.size() == 0) chk("res_unexpected", b.res_val, 1'b0);
            else begin
                r = rq.pop_front();
                chk("res_cycle", cyc, r.at);
                chk("res_sum", b.res_sum, r.sum);
                chk("res_patch", b.res_patch, r.patch);
            end
        end
        res_prev = b.res_val;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        RESET       = 1'b1;
        b.new_val   = 1'b0;
        b.new_patch = '0;
        b.new_row   = '0;
        b.new_col   = '0;
        b.red_done  = '0;
        b.red_avail = 4'b1111;
        b.red_sum   = '0;
        b.red_patch = '0;
        b.red_row   = '0;
        b.red_col   = '0;
        b.res_rdy   = 1'b0;
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
        b.cur_row   = '0;
`endif
        repeat (3) tick();
        @(negedge CLK);
        chk("rst_new_ack", b.new_ack, 1'b0);
        chk("rst_red_init", b.red_init, 4'b0);
        chk("rst_wt_rd", b.wt_rd, 1'b0);
        chk("rst_res_val", b.res_val, 1'b0);
        chk("rst_conf_sum", b.conf_sum, 32'h0);
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
        chk("rst_overrun", b.overrun, 1'b0);
`endif
        tick();
        RESET = 1'b0;

        // new patch 5, row 10, col 3 lands on reducer 0
        tick();
        n = cyc;
        iq.push_back('{4'b0001, 32'h0, 11'd10, 11'd3, 6'd5, 1'b0, n + 3});
        b.new_val = 1'b1; b.new_patch = 6'd5; b.new_row = 11'd10; b.new_col = 11'd3;
        wait_ack(n + 1);
        tick();
        b.new_val = 1'b0;
        b.red_avail[0] = 1'b0;
        set_red(0, 32'h0, 6'd5, 11'd10, 3);
        wait_q();
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
        chk("overrun_new_patch", b.overrun, 1'b0);
`endif

        // row 0 done with sum 1.5: continuation to row 11
        tick();
        n = cyc;
        set_red(0, 32'h3FC00000, 6'd5, 11'd10, 3);
        iq.push_back('{4'b0001, 32'h3FC00000, 11'd11, 11'd3, 6'd5, 1'b1, n + 4});
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
        b.cur_row = 11'd12;
`endif
        b.red_done = 4'b0001;
        tick();
        b.red_done = 4'b0000;
        wait_q();
        b.red_row[10:0] = 11'd11;
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
        chk("overrun_late_row", b.overrun, 1'b1);
`endif

        // last row done with sum 4.0: result held while res_rdy is low
        tick();
        n = cyc;
        b.red_sum[31:0] = 32'h40800000;
        rq.push_back('{32'h40800000, 6'd5, n + 2});
        b.red_done = 4'b0001;
        tick();
        b.red_done = 4'b0000;
        wait_r();
        repeat (5) begin
            @(negedge CLK);
            chk("hold_res_val", b.res_val, 1'b1);
            chk("hold_res_sum", b.res_sum, 32'h40800000);
            chk("hold_res_patch", b.res_patch, 6'd5);
        end
        tick();
        b.res_rdy = 1'b1;
        tick();
        b.res_rdy = 1'b0;
        @(negedge CLK);
        chk("res_val_drop", b.res_val, 1'b0);
        repeat (6) begin
            @(negedge CLK);
            chk("idle_after_emit_res", b.res_val, 1'b0);
            chk("idle_after_emit_init", b.red_init, 4'b0);
        end

        // simultaneous done on reducers 1 and 2 with rr at 0; new patch waits for both
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        b.red_avail = 4'b1001;
        set_red(1, 32'h3F800000, 6'd7, 11'd20, 4);
        set_red(2, 32'h40000000, 6'd9, 11'd30, 6);
        tick();
        n = cyc;
        iq.push_back('{4'b0010, 32'h3F800000, 11'd21, 11'd4, 6'd7, 1'b1, n + 4});
        iq.push_back('{4'b0100, 32'h40000000, 11'd31, 11'd6, 6'd9, 1'b1, n + 7});
        iq.push_back('{4'b0001, 32'h0, 11'd40, 11'd8, 6'd11, 1'b0, n + 10});
        b.red_done = 4'b0110;
        tick();
        b.red_done = 4'b0000;
        b.new_val = 1'b1; b.new_patch = 6'd11; b.new_row = 11'd40; b.new_col = 11'd8;
        wait_ack(n + 8);
        tick();
        b.new_val = 1'b0;
        b.red_avail[0] = 1'b0;
        wait_q();
`ifdef PATCH_SEQ_OVERRUN_CHECK_EN
        chk("overrun_cleared", b.overrun, 1'b0);
`endif

        // every reducer busy: no ack until reducer 3 becomes available
        b.red_avail = 4'b0000;
        tick();
        b.new_val = 1'b1; b.new_patch = 6'd13; b.new_row = 11'd50; b.new_col = 11'd9;
        repeat (6) begin
            @(negedge CLK);
            chk("no_ack_busy", b.new_ack, 1'b0);
        end
        tick();
        n = cyc;
        iq.push_back('{4'b1000, 32'h0, 11'd50, 11'd9, 6'd13, 1'b0, n + 3});
        b.red_avail = 4'b1000;
        wait_ack(n + 1);
        tick();
        b.new_val = 1'b0;
        b.red_avail = 4'b0000;
        wait_q();

        // reset while in ISSUE drops the job and a done arriving with it
        b.red_avail = 4'b0010;
        tick();
        n = cyc;
        iq.push_back('{4'b0010, 32'h0, 11'd60, 11'd2, 6'd15, 1'b0, n + 3});
        b.new_val = 1'b1; b.new_patch = 6'd15; b.new_row = 11'd60; b.new_col = 11'd2;
        wait_ack(n + 1);
        tick();
        b.new_val = 1'b0;
        RESET = 1'b1;
        b.red_done = 4'b0100;
        tick();
        @(negedge CLK);
        chk("rst_issue_init", b.red_init, 4'b0);
        chk("rst_issue_res", b.res_val, 1'b0);
        chk("rst_issue_wt", b.wt_rd, 1'b0);
        iq.delete();
        RESET = 1'b0;
        b.red_done = 4'b0000;
        repeat (6) begin
            @(negedge CLK);
            chk("no_pending_init", b.red_init, 4'b0);
            chk("no_pending_wt", b.wt_rd, 1'b0);
            chk("no_pending_res", b.res_val, 1'b0);
        end

        chk("iq_empty", iq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
